// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle accumulator controller:
// state encoding, opcode values, ALU function codes and the strobe bundle.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEM_RD = 4'd3,
        ST_LDA_WB = 4'd4,
        ST_ALU_WB = 4'd5,
        ST_STA_WR = 4'd6,
        ST_JMP_EX = 4'd7,
        ST_JZ_EX  = 4'd8,
        ST_HALT   = 4'd9
    } state_e;

    // Opcodes live in IR[15:13]
    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    // ALU function codes; the datapath ALU must decode exactly these.
    // The zero flag in PASS_A mode reflects A==0.
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_AND    = 2'b10;
    localparam logic [1:0] ALU_PASS_A = 2'b11;

    // Every datapath control strobe, grouped so the output decoder can
    // clear them all with a single default.
    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_acc;
        logic       acc_write;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       pc_src;
        logic [1:0] alu_func;
    } ctrl_s;

    // Arithmetic opcodes map onto their ALU function; anything else adds.
    function automatic logic [1:0] alu_func_for(input logic [2:0] op);
        logic [1:0] f;
        f = ALU_ADD;
        case (op)
            OP_SUB:  f = ALU_SUB;
            OP_AND:  f = ALU_AND;
            default: f = ALU_ADD;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the 16-bit accumulator datapath. One state per clock,
// Moore outputs, run/idle gating, a terminal HALT and a retired-instruction
// counter that wraps silently.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic [2:0]       opcode_i,
    output logic             PCWriteCond_o,
    output logic             PCWrite_o,
    output logic             IorD_o,
    output logic             memRead_o,
    output logic             memWrite_o,
    output logic             IRWrite_o,
    output logic             memToAcc_o,
    output logic             accWrite_o,
    output logic             ALUSrcA_o,
    output logic             ALUSrcB_o,
    output logic             PCSrc_o,
    output logic [1:0]       ALUFunc_o,
    output logic             busy_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] instr_count_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    ctrl_s            ctrl;

    // State and retire counter; reset may land at any point mid-instruction
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next state and retire: every final state bumps the count as it is left
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (run_i) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode_i)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND: state_d = ST_MEM_RD;
                    OP_STA:  state_d = ST_STA_WR;
                    OP_JMP:  state_d = ST_JMP_EX;
                    OP_JZ:   state_d = ST_JZ_EX;
                    default: begin
                        // HLT retires as it enters HALT
                        state_d = ST_HALT;
                        count_d = count_q + CNT_W'(1);
                    end
                endcase
            end
            ST_MEM_RD: begin
                state_d = (opcode_i == OP_LDA) ? ST_LDA_WB : ST_ALU_WB;
            end
            ST_LDA_WB, ST_ALU_WB, ST_STA_WR, ST_JMP_EX, ST_JZ_EX: begin
                count_d = count_q + CNT_W'(1);
                state_d = run_i ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore strobe decode; opcode only steers the ALU function in ALU_WB
    always_comb begin
        ctrl     = '0;
        busy_o   = 1'b1;
        halted_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
            end
            ST_FETCH: begin
                // IR <= mem[PC] and PC <= PC + 1 in the same cycle
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.alu_func  = ALU_ADD;
                ctrl.pc_write  = 1'b1;
            end
            ST_DECODE: begin
            end
            ST_MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            ST_LDA_WB: begin
                ctrl.mem_to_acc = 1'b1;
                ctrl.acc_write  = 1'b1;
            end
            ST_ALU_WB: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.acc_write = 1'b1;
                ctrl.alu_func  = alu_func_for(opcode_i);
            end
            ST_STA_WR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            ST_JMP_EX: begin
                ctrl.pc_src   = 1'b1;
                ctrl.pc_write = 1'b1;
            end
            ST_JZ_EX: begin
                // Branch resolves in the datapath from ACC==0
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_func      = ALU_PASS_A;
                ctrl.pc_src        = 1'b1;
                ctrl.pc_write_cond = 1'b1;
            end
            ST_HALT: begin
                busy_o   = 1'b0;
                halted_o = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    assign PCWriteCond_o = ctrl.pc_write_cond;
    assign PCWrite_o     = ctrl.pc_write;
    assign IorD_o        = ctrl.i_or_d;
    assign memRead_o     = ctrl.mem_read;
    assign memWrite_o    = ctrl.mem_write;
    assign IRWrite_o     = ctrl.ir_write;
    assign memToAcc_o    = ctrl.mem_to_acc;
    assign accWrite_o    = ctrl.acc_write;
    assign ALUSrcA_o     = ctrl.alu_src_a;
    assign ALUSrcB_o     = ctrl.alu_src_b;
    assign PCSrc_o       = ctrl.pc_src;
    assign ALUFunc_o     = ctrl.alu_func;
    assign instr_count_o = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench: controller plus a small behavioural datapath/memory, checked against
// an instruction-level interpreter and a per-cycle strobe table.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst_n;
    logic run;

    always #5 clk = ~clk;

    // ---------------- DUT outputs ----------------
    logic pcwc, pcw, iord, mrd, mwr, irw, m2a, accw, srca, srcb, pcsrc, busy, halted;
    logic [1:0]  func;
    logic [15:0] count;
    logic d2_pcwc, d2_pcw, d2_iord, d2_mrd, d2_mwr, d2_irw, d2_m2a, d2_accw;
    logic d2_srca, d2_srcb, d2_pcsrc, d2_busy, d2_halted;
    logic [1:0] d2_func;
    logic [1:0] count2;

    // ---------------- behavioural datapath ----------------
    logic [15:0] dp_mem [0:8191];
    logic [12:0] dp_pc;
    logic [15:0] dp_ir, dp_mdr, dp_acc;
    logic        ld_en = 1'b0;
    logic [12:0] ld_addr = '0;
    logic [15:0] ld_data = '0;

    multicycle_controller #(.CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .run_i(run), .opcode_i(dp_ir[15:13]),
        .PCWriteCond_o(pcwc), .PCWrite_o(pcw), .IorD_o(iord), .memRead_o(mrd),
        .memWrite_o(mwr), .IRWrite_o(irw), .memToAcc_o(m2a), .accWrite_o(accw),
        .ALUSrcA_o(srca), .ALUSrcB_o(srcb), .PCSrc_o(pcsrc), .ALUFunc_o(func),
        .busy_o(busy), .halted_o(halted), .instr_count_o(count)
    );

    // Narrow-counter copy: same inputs, only the count width differs
    multicycle_controller #(.CNT_W(2)) dut_w2 (
        .clk_i(clk), .rst_ni(rst_n), .run_i(run), .opcode_i(dp_ir[15:13]),
        .PCWriteCond_o(d2_pcwc), .PCWrite_o(d2_pcw), .IorD_o(d2_iord), .memRead_o(d2_mrd),
        .memWrite_o(d2_mwr), .IRWrite_o(d2_irw), .memToAcc_o(d2_m2a), .accWrite_o(d2_accw),
        .ALUSrcA_o(d2_srca), .ALUSrcB_o(d2_srcb), .PCSrc_o(d2_pcsrc), .ALUFunc_o(d2_func),
        .busy_o(d2_busy), .halted_o(d2_halted), .instr_count_o(count2)
    );

    wire [14:0] vec  = {pcwc, pcw, iord, mrd, mwr, irw, m2a, accw, srca, srcb, pcsrc, func, busy, halted};
    wire [14:0] vec2 = {d2_pcwc, d2_pcw, d2_iord, d2_mrd, d2_mwr, d2_irw, d2_m2a, d2_accw,
                        d2_srca, d2_srcb, d2_pcsrc, d2_func, d2_busy, d2_halted};

    // ALU as the datapath implements it
    logic [15:0] alu_a, alu_b, alu_res;
    always_comb begin
        alu_a = srca ? dp_acc : {3'b000, dp_pc};
        alu_b = srcb ? 16'd1 : dp_mdr;
        case (func)
            2'b00:   alu_res = alu_a + alu_b;
            2'b01:   alu_res = alu_a - alu_b;
            2'b10:   alu_res = alu_a & alu_b;
            default: alu_res = alu_a;
        endcase
    end
    wire alu_zero = (alu_res == 16'd0);

    always @(posedge clk) begin
        if (ld_en) dp_mem[ld_addr] <= ld_data;
        if (!rst_n) begin
            dp_pc <= '0;
            dp_ir <= '0;
        end else begin
            if (mrd && !iord && irw) dp_ir <= dp_mem[dp_pc];
            if (mrd && iord) dp_mdr <= dp_mem[dp_ir[12:0]];
            if (mwr) dp_mem[iord ? dp_ir[12:0] : dp_pc] <= dp_acc;
            if (accw) dp_acc <= m2a ? dp_mdr : alu_res;
            if (pcw || (pcwc && alu_zero)) dp_pc <= pcsrc ? dp_ir[12:0] : alu_res[12:0];
        end
    end

    // ---------------- reference model ----------------
    logic [15:0] model_mem [0:8191];
    logic [12:0] model_pc;
    logic [15:0] model_acc;
    int unsigned model_count;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected strobes for cycle k of an instruction (k=0 is FETCH)
    function automatic logic [14:0] exp_vec(input logic [2:0] op, input int k);
        logic [14:0] v;
        v    = '0;
        v[1] = 1'b1;                                   // busy
        if (k == 0) begin
            v[13] = 1'b1; v[11] = 1'b1; v[9] = 1'b1; v[5] = 1'b1;
        end else if (k == 2) begin
            case (op)
                3'd1:    begin v[12] = 1'b1; v[10] = 1'b1; end
                3'd5:    begin v[4] = 1'b1; v[13] = 1'b1; end
                3'd6:    begin v[6] = 1'b1; v[3:2] = 2'b11; v[4] = 1'b1; v[14] = 1'b1; end
                default: begin v[12] = 1'b1; v[11] = 1'b1; end
            endcase
        end else if (k == 3) begin
            if (op == 3'd0) begin
                v[8] = 1'b1; v[7] = 1'b1;
            end else begin
                v[6] = 1'b1; v[7] = 1'b1;
                v[3:2] = (op == 3'd2) ? 2'b00 : (op == 3'd3) ? 2'b01 : 2'b10;
            end
        end
        return v;
    endfunction

    task automatic load_word(input logic [12:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        model_mem[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Runs one instruction from FETCH; drop_sel: -1 keep run, -2 random drop, >=0 drop at that cycle
    task automatic exec_one(input int drop_sel, input int idle_n);
        logic [2:0]  op;
        logic [12:0] a;
        int          lat;
        int          drop_k;
        op     = model_mem[model_pc][15:13];
        a      = model_mem[model_pc][12:0];
        lat    = (op == 3'd7) ? 2 : (op == 3'd1 || op == 3'd5 || op == 3'd6) ? 3 : 4;
        drop_k = (drop_sel == -2) ? $urandom_range(0, lat - 1) : drop_sel;
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            chk($sformatf("strobe op%0d k%0d", op, k), 32'(vec), 32'(exp_vec(op, k)));
            chk($sformatf("strobe_w2 op%0d k%0d", op, k), 32'(vec2), 32'(exp_vec(op, k)));
            if (k == drop_k) run = 1'b0;
        end
        model_pc = model_pc + 13'd1;
        case (op)
            3'd0: model_acc = model_mem[a];
            3'd1: model_mem[a] = model_acc;
            3'd2: model_acc = model_acc + model_mem[a];
            3'd3: model_acc = model_acc - model_mem[a];
            3'd4: model_acc = model_acc & model_mem[a];
            3'd5: model_pc = a;
            3'd6: if (model_acc == 16'd0) model_pc = a;
            default: ;
        endcase
        model_count++;
        @(posedge clk);
        #1;
        chk("pc", 32'(dp_pc), 32'(model_pc));
        chk("acc", 32'(dp_acc), 32'(model_acc));
        chk("count", 32'(count), model_count & 32'hFFFF);
        chk("count_w2", 32'(count2), model_count & 32'h3);
        if (op == 3'd1) chk("sta_mem", 32'(dp_mem[a]), 32'(model_mem[a]));
        $display("instr op=%0d addr=%04h -> pc=%04h acc=%04h count=%0d", op, a, dp_pc, dp_acc, count);
        if (drop_k >= 0) begin
            for (int j = 0; j < idle_n; j++) begin
                @(negedge clk);
                chk("idle_strobes", 32'(vec), 32'h0);
            end
            run = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        run         = 1'b0;
        model_pc    = '0;
        model_acc   = '0;
        model_count = 0;
        repeat (3) @(negedge clk);
        chk("reset_strobes", 32'(vec), 32'h0);
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_count_w2", 32'(count2), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_strobes", 32'(vec), 32'h0);

        // Directed program: LDA 5, ADD 2 (=7), SUB 3 (=4), AND 6 (=4), STA 0x20,
        // JZ not taken, LDA 0, JZ taken to 0x40, JMP 0x100
        load_word(13'h000, {3'd0, 13'h010});
        load_word(13'h001, {3'd2, 13'h011});
        load_word(13'h002, {3'd3, 13'h012});
        load_word(13'h003, {3'd4, 13'h013});
        load_word(13'h004, {3'd1, 13'h020});
        load_word(13'h005, {3'd6, 13'h030});
        load_word(13'h006, {3'd0, 13'h014});
        load_word(13'h007, {3'd6, 13'h040});
        load_word(13'h040, {3'd5, 13'h100});
        load_word(13'h010, 16'h0005);
        load_word(13'h011, 16'h0002);
        load_word(13'h012, 16'h0003);
        load_word(13'h013, 16'h0006);
        load_word(13'h014, 16'h0000);
        load_word(13'h020, 16'hDEAD);
        // Random program at 0x100..0x13F with data at 0x200..0x23F
        for (int i = 0; i < 64; i++) begin
            logic [2:0]  op;
            logic [12:0] ad;
            op = 3'($urandom_range(0, 6));
            if (op == 3'd5 || op == 3'd6) ad = 13'h100 + 13'($urandom_range(0, 63));
            else                          ad = 13'h200 + 13'($urandom_range(0, 63));
            if (i == 63) begin op = 3'd5; ad = 13'h100; end
            load_word(13'h100 + 13'(i), {op, ad});
        end
        for (int i = 0; i < 64; i++)
            load_word(13'h200 + 13'(i), ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));

        run = 1'b1;
        exec_one(-1, 0);
        chk("lda_acc", 32'(dp_acc), 32'h5);
        chk("lda_pc", 32'(dp_pc), 32'h1);
        exec_one(2, 3);                 // run dropped during MEM_RD of ADD
        chk("add_acc", 32'(dp_acc), 32'h7);
        exec_one(-1, 0);
        exec_one(-1, 0);
        exec_one(-1, 0);
        chk("sta_result", 32'(dp_mem[13'h020]), 32'h4);
        chk("count5", 32'(count), 32'd5);
        exec_one(-1, 0);                // JZ not taken
        chk("jz_nt_pc", 32'(dp_pc), 32'h6);
        exec_one(-1, 0);
        exec_one(-1, 0);                // JZ taken
        chk("jz_t_pc", 32'(dp_pc), 32'h40);
        exec_one(-1, 0);                // JMP 0x100
        chk("jmp_pc", 32'(dp_pc), 32'h100);

        for (int n = 0; n < 60; n++)
            exec_one(($urandom_range(0, 4) == 0) ? -2 : -1, $urandom_range(1, 3));

        // Asynchronous reset in the middle of STA_WR
        @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        load_word(13'h000, {3'd1, 13'h020});
        rst_n       = 1'b1;
        model_pc    = '0;
        model_count = 0;
        run         = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("sta_pre_rst k%0d", k), 32'(vec), 32'(exp_vec(3'd1, k)));
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_memwrite", 32'(mwr), 32'h0);
        chk("rst_strobes", 32'(vec), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_count_w2", 32'(count2), 32'h0);
        run = 1'b0;
        @(negedge clk);
        load_word(13'h000, {3'd7, 13'h000});
        rst_n = 1'b1;
        run   = 1'b1;

        // HLT: retires once, then HALT ignores run
        exec_one(-1, 0);
        chk("halt_flags", 32'({busy, halted}), 32'h1);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            run = 1'($urandom);
            chk("halt_strobes", 32'(vec), 32'h1);
            chk("halt_count", 32'(count), 32'h1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
